// File: rtl/xhci_cmd_pkg.sv
// Shared definitions for the xHCI endpoint-command front end: TRB type codes,
// completion codes, endpoint states, FSM states and the set-ep-tr bus layout.
package xhci_cmd_pkg;

    localparam logic [5:0] RESET_EP   = 6'd14;
    localparam logic [5:0] STOP_EP    = 6'd15;
    localparam logic [5:0] SET_TR_DEQ = 6'd16;

    typedef enum logic [7:0] {
        SUCCESS     = 8'd1,
        TRB_ERR     = 8'd5,
        SLOT_NOT_EN = 8'd11,
        PARAM_ERR   = 8'd17,
        CMD_ABORTED = 8'd25
    } comp_code_e;

    typedef enum logic [2:0] {
        STOPPED = 3'd3
    } ep_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EP_REQ,
        ST_EP_RELEASE,
        ST_TR_UPDATE,
        ST_EVENT
    } cmd_state_e;

    // Bit positions on the 74-bit set-ep-tr bus.
    localparam int SET_EP_TR_W        = 74;
    localparam int SET_EP_TR_RUN      = 0;
    localparam int SET_EP_TR_SLOT_LSB = 1;
    localparam int SET_EP_TR_DCI_LSB  = 4;
    localparam int SET_EP_TR_PTR_LSB  = 9;
    localparam int SET_EP_TR_CYCLE    = 73;

    // Assemble one set-ep-tr word; the run bit is always set for a live update.
    function automatic logic [SET_EP_TR_W-1:0] pack_set_ep_tr(
        input logic        dcs,
        input logic [63:0] ptr,
        input logic [4:0]  dci,
        input logic [2:0]  slot
    );
        logic [SET_EP_TR_W-1:0] v;
        v = '0;
        v[SET_EP_TR_RUN]                = 1'b1;
        v[SET_EP_TR_SLOT_LSB +: 3]      = slot;
        v[SET_EP_TR_DCI_LSB +: 5]       = dci;
        v[SET_EP_TR_PTR_LSB +: 64]      = ptr;
        v[SET_EP_TR_CYCLE]              = dcs;
        return v;
    endfunction

endpackage

// File: rtl/ep_cmd_dispatch_if.sv
// Bundle of command, endpoint-writer, context-update and event signals
// exchanged between the endpoint-command dispatcher and its neighbours.
interface ep_cmd_dispatch_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [127:0] cmd_trb;
    logic [7:0]   slot_enabled;
    logic         ep_req;
    logic [7:0]   ep_req_slot_id;
    logic [4:0]   ep_req_ep_id;
    logic [2:0]   ep_req_state;
    logic         ep_req_done;
    logic [73:0]  set_ep_tr;
    logic         evt_valid;
    logic         evt_ready;
    logic [7:0]   evt_comp_code;
    logic [7:0]   evt_slot_id;
    logic         busy;

    modport master (
        output cmd_valid, cmd_trb, slot_enabled, ep_req_done, evt_ready,
        input  cmd_ready, ep_req, ep_req_slot_id, ep_req_ep_id, ep_req_state,
               set_ep_tr, evt_valid, evt_comp_code, evt_slot_id, busy
    );

    modport slave (
        input  cmd_valid, cmd_trb, slot_enabled, ep_req_done, evt_ready,
        output cmd_ready, ep_req, ep_req_slot_id, ep_req_ep_id, ep_req_state,
               set_ep_tr, evt_valid, evt_comp_code, evt_slot_id, busy
    );
endinterface

// File: rtl/ep_cmd_decode.sv
// Combinational TRB field extraction and validity checks. Produces the state
// to enter after DECODE and the completion code to report.
module ep_cmd_decode
    import xhci_cmd_pkg::*;
#(
    parameter int MAX_SLOT_ID = 7
) (
    input  logic [127:0]           trb,
    input  logic [7:0]             slot_enabled,
    output cmd_state_e             next_state,
    output comp_code_e             code,
    output logic [7:0]             slot,
    output logic [4:0]             dci,
    output logic [SET_EP_TR_W-1:0] set_ep_tr_val
);

    logic [5:0]  trb_type;
    logic [2:0]  sct;
    logic        dcs;
    logic [63:0] ptr;
    logic [2:0]  slot_idx;
    logic        unused_trb_bits;

    assign trb_type = trb[111:106];
    assign dci      = trb[116:112];
    assign slot     = trb[127:120];
    assign dcs      = trb[0];
    assign sct      = trb[3:1];
    assign ptr      = {trb[63:4], 4'b0};
    assign slot_idx = slot[2:0] - 3'd1;

    assign set_ep_tr_val   = pack_set_ep_tr(dcs, ptr, dci, slot[2:0]);
    assign unused_trb_bits = ^{trb[119:117], trb[105:64]};

    // Priority-ordered checks; the first failing check decides the code.
    always_comb begin
        next_state = ST_EVENT;
        code       = SUCCESS;
        if (!((trb_type == RESET_EP) || (trb_type == STOP_EP) || (trb_type == SET_TR_DEQ))) begin
            code = TRB_ERR;
        end else if ((slot == 8'd0) || (slot > 8'(MAX_SLOT_ID)) || (dci == 5'd0)) begin
            code = TRB_ERR;
        end else if (!slot_enabled[slot_idx]) begin
            code = SLOT_NOT_EN;
        end else if ((trb_type == SET_TR_DEQ) && (sct != 3'd0)) begin
            code = PARAM_ERR;
        end else if (trb_type == SET_TR_DEQ) begin
            next_state = ST_TR_UPDATE;
        end else begin
            next_state = ST_EP_REQ;
        end
    end

endmodule

// File: rtl/ep_cmd_dispatch.sv
// Endpoint-command front end for the xHCI command ring: accepts one command
// TRB at a time, drives the endpoint-state writer or the set-ep-tr bus, and
// reports one completion record per accepted TRB.
module ep_cmd_dispatch
    import xhci_cmd_pkg::*;
#(
    parameter int MAX_SLOT_ID    = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic               clk,
    input logic               rst,
    ep_cmd_dispatch_if.slave  bus
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    cmd_state_e             state;
    logic [127:0]           trb_q;
    logic [WD_W-1:0]        wd_q;
    logic                   ep_req_q;
    logic [7:0]             slot_q;
    logic [4:0]             dci_q;
    logic [2:0]             ep_state_q;
    logic [SET_EP_TR_W-1:0] set_ep_tr_q;
    logic                   evt_valid_q;
    logic [7:0]             code_q;

    cmd_state_e             dec_next;
    comp_code_e             dec_code;
    logic [7:0]             dec_slot;
    logic [4:0]             dec_dci;
    logic [SET_EP_TR_W-1:0] dec_set_ep_tr;

    ep_cmd_decode #(.MAX_SLOT_ID(MAX_SLOT_ID)) u_decode (
        .trb           (trb_q),
        .slot_enabled  (bus.slot_enabled),
        .next_state    (dec_next),
        .code          (dec_code),
        .slot          (dec_slot),
        .dci           (dec_dci),
        .set_ep_tr_val (dec_set_ep_tr)
    );

    assign bus.cmd_ready      = (state == ST_IDLE);
    assign bus.busy           = (state != ST_IDLE);
    assign bus.ep_req         = ep_req_q;
    assign bus.ep_req_slot_id = slot_q;
    assign bus.ep_req_ep_id   = dci_q;
    assign bus.ep_req_state   = ep_state_q;
    assign bus.set_ep_tr      = set_ep_tr_q;
    assign bus.evt_valid      = evt_valid_q;
    assign bus.evt_comp_code  = code_q;
    assign bus.evt_slot_id    = slot_q;

    // Command FSM with registered outputs and the endpoint-writer watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            trb_q       <= '0;
            wd_q        <= '0;
            ep_req_q    <= 1'b0;
            slot_q      <= '0;
            dci_q       <= '0;
            ep_state_q  <= '0;
            set_ep_tr_q <= '0;
            evt_valid_q <= 1'b0;
            code_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        trb_q <= bus.cmd_trb;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state  <= dec_next;
                    code_q <= dec_code;
                    slot_q <= dec_slot;
                    dci_q  <= dec_dci;
                    wd_q   <= '0;
                    if (dec_next == ST_EP_REQ) begin
                        ep_req_q   <= 1'b1;
                        ep_state_q <= STOPPED;
                    end
                    if (dec_next == ST_TR_UPDATE) begin
                        set_ep_tr_q <= dec_set_ep_tr;
                    end
                    if (dec_next == ST_EVENT) begin
                        evt_valid_q <= 1'b1;
                    end
                end
                ST_EP_REQ: begin
                    if (bus.ep_req_done) begin
                        ep_req_q <= 1'b0;
                        code_q   <= SUCCESS;
                        state    <= ST_EP_RELEASE;
                    end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        ep_req_q <= 1'b0;
                        code_q   <= CMD_ABORTED;
                        state    <= ST_EP_RELEASE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_EP_RELEASE: begin
                    if (!bus.ep_req_done) begin
                        evt_valid_q <= 1'b1;
                        state       <= ST_EVENT;
                    end
                end
                ST_TR_UPDATE: begin
                    set_ep_tr_q <= '0;
                    evt_valid_q <= 1'b1;
                    state       <= ST_EVENT;
                end
                ST_EVENT: begin
                    if (bus.evt_ready) begin
                        evt_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ep_cmd_dispatch.sv
// Self-checking bench for ep_cmd_dispatch: a vector table of commands with
// expected completion records, plus sequences for timeout, back-pressure and
// reset in the middle of an endpoint request.
module tb_ep_cmd_dispatch;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] slot;
    } evt_exp_t;

    typedef struct {
        string        name;
        logic [127:0] trb;
        logic [7:0]   slot_en;
        logic [7:0]   exp_code;
        logic [7:0]   exp_slot;
        logic [4:0]   exp_dci;
        logic         exp_ep;
        logic         exp_set;
        logic [73:0]  exp_set_val;
    } vec_t;

    logic clk;
    logic rst;

    ep_cmd_dispatch_if bus ();

    ep_cmd_dispatch #(
        .MAX_SLOT_ID    (7),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int ep_cycles    = 0;
    int set_cycles   = 0;

    evt_exp_t    exp_evt_q[$];
    logic [73:0] exp_set_q[$];
    vec_t        vecs[12];

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] make_trb(input logic [5:0] t, input logic [7:0] slot, input logic [4:0] dci,
                                              input logic [2:0] sct, input logic dcs, input logic [63:0] ptr);
        logic [127:0] r;
        r = '0;
        r[111:106] = t;
        r[116:112] = dci;
        r[127:120] = slot;
        r[3:1]     = sct;
        r[0]       = dcs;
        r[63:4]    = ptr[63:4];
        return r;
    endfunction

    // Scoreboard side: pop expectations whenever a record or bus update appears.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ep_req) ep_cycles++;
            if (bus.set_ep_tr != '0) begin
                set_cycles++;
                if (exp_set_q.size() == 0) begin
                    checkOutput("set_ep_tr_unexpected", 128'(bus.set_ep_tr), 128'd0);
                end else begin
                    checkOutput("set_ep_tr_value", 128'(bus.set_ep_tr), 128'(exp_set_q.pop_front()));
                end
            end
            if (bus.evt_valid && bus.evt_ready) begin
                if (exp_evt_q.size() == 0) begin
                    checkOutput("evt_unexpected", 128'({bus.evt_comp_code, bus.evt_slot_id}), 128'd0);
                end else begin
                    evt_exp_t e;
                    e = exp_evt_q.pop_front();
                    checkOutput("evt_comp_code", 128'(bus.evt_comp_code), 128'(e.code));
                    checkOutput("evt_slot_id", 128'(bus.evt_slot_id), 128'(e.slot));
                end
            end
        end
    end

    task automatic sendCmd(input logic [127:0] trb, input logic [7:0] en);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        if (!bus.cmd_ready) checkOutput("cmd_ready_timeout", 128'(bus.cmd_ready), 128'd1);
        bus.slot_enabled = en;
        bus.cmd_trb      = trb;
        bus.cmd_valid    = 1'b1;
        @(posedge clk) #1;
        bus.cmd_valid    = 1'b0;
    endtask

    task automatic waitEpReq();
        int n;
        n = 0;
        while (!bus.ep_req && n < 20) begin
            @(posedge clk) #1;
            n++;
        end
        checkOutput("ep_req_seen", 128'(bus.ep_req), 128'd1);
    endtask

    task automatic waitEventsDrained();
        int n;
        n = 0;
        while (exp_evt_q.size() != 0 && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        checkOutput("evt_drained", 128'(exp_evt_q.size()), 128'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        ep_cycles  = 0;
        set_cycles = 0;
        exp_evt_q.push_back('{code: v.exp_code, slot: v.exp_slot});
        if (v.exp_set) exp_set_q.push_back(v.exp_set_val);
        sendCmd(v.trb, v.slot_en);
        if (v.exp_ep) begin
            waitEpReq();
            checkOutput({v.name, "_ep_slot"}, 128'(bus.ep_req_slot_id), 128'(v.exp_slot));
            checkOutput({v.name, "_ep_dci"}, 128'(bus.ep_req_ep_id), 128'(v.exp_dci));
            checkOutput({v.name, "_ep_state"}, 128'(bus.ep_req_state), 128'd3);
            bus.ep_req_done = 1'b1;
            @(posedge clk) #1;
            checkOutput({v.name, "_ep_req_drop"}, 128'(bus.ep_req), 128'd0);
            @(posedge clk) #1;
            bus.ep_req_done = 1'b0;
        end
        waitEventsDrained();
        checkOutput({v.name, "_ep_cycles"}, 128'(ep_cycles), v.exp_ep ? 128'd1 : 128'd0);
        checkOutput({v.name, "_set_cycles"}, 128'(set_cycles), v.exp_set ? 128'd1 : 128'd0);
        checkOutput({v.name, "_set_drained"}, 128'(exp_set_q.size()), 128'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_trb      = '0;
        bus.slot_enabled = '0;
        bus.ep_req_done  = 1'b0;
        bus.evt_ready    = 1'b1;

        vecs[0]  = '{"stop_s2_d3",   make_trb(6'd15, 8'd2, 5'd3, 3'd0, 1'b0, 64'd0), 8'hFF, 8'd1,  8'd2, 5'd3,  1'b1, 1'b0, 74'd0};
        vecs[1]  = '{"settr_s1_d1",  make_trb(6'd16, 8'd1, 5'd1, 3'd0, 1'b1, 64'h0000_0001_2345_6780), 8'hFF, 8'd1, 8'd1, 5'd1, 1'b0, 1'b1,
                     {1'b1, 64'h0000_0001_2345_6780, 5'd1, 3'd1, 1'b1}};
        vecs[2]  = '{"stop_s5_off",  make_trb(6'd15, 8'd5, 5'd1, 3'd0, 1'b0, 64'd0), 8'h01, 8'd11, 8'd5, 5'd1,  1'b0, 1'b0, 74'd0};
        vecs[3]  = '{"settr_sct3",   make_trb(6'd16, 8'd1, 5'd1, 3'd3, 1'b0, 64'h100), 8'hFF, 8'd17, 8'd1, 5'd1, 1'b0, 1'b0, 74'd0};
        vecs[4]  = '{"type9",        make_trb(6'd9,  8'd1, 5'd1, 3'd0, 1'b0, 64'd0), 8'hFF, 8'd5,  8'd1, 5'd1,  1'b0, 1'b0, 74'd0};
        vecs[5]  = '{"slot0",        make_trb(6'd15, 8'd0, 5'd1, 3'd0, 1'b0, 64'd0), 8'hFF, 8'd5,  8'd0, 5'd1,  1'b0, 1'b0, 74'd0};
        vecs[6]  = '{"reset_s7_d31", make_trb(6'd14, 8'd7, 5'd31, 3'd0, 1'b0, 64'd0), 8'h40, 8'd1, 8'd7, 5'd31, 1'b1, 1'b0, 74'd0};
        vecs[7]  = '{"slot8",        make_trb(6'd15, 8'd8, 5'd1, 3'd0, 1'b0, 64'd0), 8'hFF, 8'd5,  8'd8, 5'd1,  1'b0, 1'b0, 74'd0};
        vecs[8]  = '{"dci0",         make_trb(6'd14, 8'd2, 5'd0, 3'd0, 1'b0, 64'd0), 8'hFF, 8'd5,  8'd2, 5'd0,  1'b0, 1'b0, 74'd0};
        vecs[9]  = '{"settr_s3_max", make_trb(6'd16, 8'd3, 5'd2, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF), 8'h04, 8'd1, 8'd3, 5'd2, 1'b0, 1'b1,
                     {1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 5'd2, 3'd3, 1'b1}};
        vecs[10] = '{"settr_off_sct",make_trb(6'd16, 8'd2, 5'd1, 3'd3, 1'b0, 64'd0), 8'h01, 8'd11, 8'd2, 5'd1,  1'b0, 1'b0, 74'd0};
        vecs[11] = '{"type17",       make_trb(6'd17, 8'd1, 5'd1, 3'd0, 1'b0, 64'd0), 8'hFF, 8'd5,  8'd1, 5'd1,  1'b0, 1'b0, 74'd0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        checkOutput("rst_outputs", 128'({bus.busy, bus.ep_req, bus.evt_valid, bus.evt_comp_code, bus.evt_slot_id,
                                         bus.ep_req_slot_id, bus.ep_req_ep_id, bus.ep_req_state}), 128'd0);
        checkOutput("rst_set_ep_tr", 128'(bus.set_ep_tr), 128'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
        end

        // Endpoint writer never answers: the watchdog must abort after 16 cycles.
        ep_cycles = 0;
        exp_evt_q.push_back('{code: 8'd25, slot: 8'd2});
        sendCmd(make_trb(6'd14, 8'd2, 5'd3, 3'd0, 1'b0, 64'd0), 8'hFF);
        waitEventsDrained();
        checkOutput("timeout_ep_cycles", 128'(ep_cycles), 128'd16);

        // Event writer stalls for 10 cycles; the record must stay put.
        bus.evt_ready = 1'b0;
        exp_evt_q.push_back('{code: 8'd11, slot: 8'd5});
        sendCmd(make_trb(6'd15, 8'd5, 5'd1, 3'd0, 1'b0, 64'd0), 8'h01);
        for (int n = 0; n < 20 && !bus.evt_valid; n++) @(posedge clk) #1;
        for (int c = 0; c < 10; c++) begin
            checkOutput("stall_hold", 128'({bus.evt_valid, bus.evt_comp_code, bus.evt_slot_id, bus.cmd_ready, bus.busy}),
                        128'({1'b1, 8'd11, 8'd5, 1'b0, 1'b1}));
            @(posedge clk) #1;
        end
        bus.evt_ready = 1'b1;
        waitEventsDrained();

        // Reset lands while ep_req is up: no record may follow.
        sendCmd(make_trb(6'd15, 8'd2, 5'd3, 3'd0, 1'b0, 64'd0), 8'hFF);
        waitEpReq();
        rst = 1'b1;
        @(posedge clk) #1;
        checkOutput("rst_mid_ep_req", 128'(bus.ep_req), 128'd0);
        rst = 1'b0;
        @(posedge clk) #1;
        checkOutput("rst_mid_after", 128'({bus.cmd_ready, bus.busy, bus.evt_valid}), 128'({1'b1, 1'b0, 1'b0}));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_mid_no_evt", 128'(bus.evt_valid), 128'd0);

        applyStimulus(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
